// File: rtl/vga_pkg.sv
// Shared raster constants, pixel layout, FSM states and accumulator widths
// for the colour-centroid locator and its divider.
package vga_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int HALF_BOX = 64;

    localparam int SUM_W = 29;
    localparam int CNT_W = 19;
    localparam int POS_W = 10;

    localparam logic [7:0]  R_MIN      = 8'd160;
    localparam logic [7:0]  GB_MAX     = 8'd96;
    localparam logic [19:0] MIN_PIXELS = 20'd64;

    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIV_ROW,
        ST_DIV_COL,
        ST_PUBLISH
    } state_t;

    function automatic logic is_target(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return (r >= R_MIN) && (g <= GB_MAX) && (b <= GB_MAX);
    endfunction
endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle,
// with a one-cycle done pulse alongside the final quotient.
module serial_divider #(
    parameter int DIVIDEND_W = 29,
    parameter int DIVISOR_W  = 19
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient
);
    localparam int CW = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    logic               ge;

    // Remainder stays below the divisor, so trial < 2*divisor and the
    // restored or subtracted value always fits back in DIVISOR_W bits.
    assign trial = {rem_q, quot_q[DIVIDEND_W-1]};
    assign diff  = trial - {1'b0, divisor_q};
    assign ge    = (trial >= {1'b0, divisor_q});

    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (i_start) begin
            rem_d     = '0;
            quot_d    = i_dividend;
            divisor_d = i_divisor;
            count_d   = CW'(DIVIDEND_W);
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d   = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
            quot_d  = {quot_q[DIVIDEND_W-2:0], ge};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_quotient = quot_q;
endmodule

// File: rtl/color_centroid_locator.sv
// Thresholds an RGB raster, accumulates target-pixel coordinates per frame and
// publishes the clamped centroid for the overlay square after each frame end.
module color_centroid_locator import vga_pkg::*; #(
    parameter int          H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int          V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int          HALF_BOX   = vga_pkg::HALF_BOX,
    parameter logic [19:0] MIN_PIXELS = vga_pkg::MIN_PIXELS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [31:0]      i_data,
    output logic             o_valid,
    output logic             o_found,
    output logic [POS_W-1:0] o_row,
    output logic [POS_W-1:0] o_col,
    output logic             o_overrun
);
    localparam logic [POS_W-1:0] COL_LAST = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(V_ACTIVE - 1);
    localparam logic [POS_W-1:0] RST_ROW  = POS_W'(V_ACTIVE / 2);
    localparam logic [POS_W-1:0] RST_COL  = POS_W'(H_ACTIVE / 2);
    localparam logic [SUM_W-1:0] ROW_LO   = SUM_W'(HALF_BOX);
    localparam logic [SUM_W-1:0] ROW_HI   = SUM_W'(V_ACTIVE - HALF_BOX - 1);
    localparam logic [SUM_W-1:0] COL_LO   = SUM_W'(HALF_BOX);
    localparam logic [SUM_W-1:0] COL_HI   = SUM_W'(H_ACTIVE - HALF_BOX - 1);

    function automatic logic [POS_W-1:0] clamp(input logic [SUM_W-1:0] v,
                                               input logic [SUM_W-1:0] lo,
                                               input logic [SUM_W-1:0] hi);
        logic [SUM_W-1:0] c;
        c = v;
        if (v < lo)      c = lo;
        else if (v > hi) c = hi;
        return POS_W'(c);
    endfunction

    pixel_t px;
    logic   unused_pad;
    assign px         = pixel_t'(i_data);
    assign unused_pad = ^px.pad;

    logic [POS_W-1:0] col_q, col_d, row_q, row_d;
    logic [SUM_W-1:0] sum_row_q, sum_row_d, sum_col_q, sum_col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] snap_row_q, snap_row_d, snap_col_q, snap_col_d;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [SUM_W-1:0] q_row_q, q_row_d, q_col_q, q_col_d;
    state_t           state_q, state_d;
    logic             detect_q, detect_d;
    logic             valid_q, valid_d, found_q, found_d, overrun_q, overrun_d;
    logic [POS_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;

    logic             sof_beat, hit, frame_end;
    logic [POS_W-1:0] eff_row, eff_col;
    logic [SUM_W-1:0] acc_row, acc_col;
    logic [CNT_W-1:0] acc_cnt;

    logic             div_start, div_busy, div_done;
    logic [SUM_W-1:0] div_dividend, div_quot;

    // A start-of-frame beat is treated as (0,0) over empty accumulators, so
    // anything gathered from a misaligned frame never reaches a snapshot.
    assign sof_beat  = i_valid && i_sof;
    assign eff_row   = sof_beat ? '0 : row_q;
    assign eff_col   = sof_beat ? '0 : col_q;
    assign hit       = i_valid && is_target(px.r, px.g, px.b);
    assign frame_end = i_valid && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    assign acc_row   = (sof_beat ? '0 : sum_row_q) + (hit ? SUM_W'(eff_row) : '0);
    assign acc_col   = (sof_beat ? '0 : sum_col_q) + (hit ? SUM_W'(eff_col) : '0);
    assign acc_cnt   = (sof_beat ? '0 : cnt_q) + (hit ? CNT_W'(1) : '0);

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        sum_row_d  = sum_row_q;
        sum_col_d  = sum_col_q;
        cnt_d      = cnt_q;
        snap_row_d = snap_row_q;
        snap_col_d = snap_col_q;
        snap_cnt_d = snap_cnt_q;
        overrun_d  = overrun_q;
        if (i_valid) begin
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + POS_W'(1);
            end else begin
                col_d = eff_col + POS_W'(1);
                row_d = eff_row;
            end
            if (frame_end) begin
                sum_row_d = '0;
                sum_col_d = '0;
                cnt_d     = '0;
                if (state_q == ST_IDLE) begin
                    snap_row_d = acc_row;
                    snap_col_d = acc_col;
                    snap_cnt_d = acc_cnt;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                sum_row_d = acc_row;
                sum_col_d = acc_col;
                cnt_d     = acc_cnt;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        detect_d     = detect_q;
        div_start    = 1'b0;
        div_dividend = snap_row_q;
        q_row_d      = q_row_q;
        q_col_d      = q_col_q;
        valid_d      = 1'b0;
        found_d      = found_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_end) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // The count guard also keeps a zero divisor out of the divider.
                if ({1'b0, snap_cnt_q} < MIN_PIXELS) begin
                    detect_d = 1'b0;
                    state_d  = ST_PUBLISH;
                end else begin
                    detect_d  = 1'b1;
                    div_start = 1'b1;
                    state_d   = ST_DIV_ROW;
                end
            end
            ST_DIV_ROW: begin
                if (div_done && !div_busy) begin
                    q_row_d      = div_quot;
                    div_start    = 1'b1;
                    div_dividend = snap_col_q;
                    state_d      = ST_DIV_COL;
                end
            end
            ST_DIV_COL: begin
                if (div_done && !div_busy) begin
                    q_col_d = div_quot;
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                valid_d = 1'b1;
                found_d = detect_q;
                if (detect_q) begin
                    out_row_d = clamp(q_row_q, ROW_LO, ROW_HI);
                    out_col_d = clamp(q_col_q, COL_LO, COL_HI);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (div_start),
        .i_dividend (div_dividend),
        .i_divisor  (snap_cnt_q),
        .o_busy     (div_busy),
        .o_done     (div_done),
        .o_quotient (div_quot)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            sum_row_q  <= '0;
            sum_col_q  <= '0;
            cnt_q      <= '0;
            snap_row_q <= '0;
            snap_col_q <= '0;
            snap_cnt_q <= '0;
            q_row_q    <= '0;
            q_col_q    <= '0;
            state_q    <= ST_IDLE;
            detect_q   <= 1'b0;
            valid_q    <= 1'b0;
            found_q    <= 1'b0;
            overrun_q  <= 1'b0;
            out_row_q  <= RST_ROW;
            out_col_q  <= RST_COL;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            sum_row_q  <= sum_row_d;
            sum_col_q  <= sum_col_d;
            cnt_q      <= cnt_d;
            snap_row_q <= snap_row_d;
            snap_col_q <= snap_col_d;
            snap_cnt_q <= snap_cnt_d;
            q_row_q    <= q_row_d;
            q_col_q    <= q_col_d;
            state_q    <= state_d;
            detect_q   <= detect_d;
            valid_q    <= valid_d;
            found_q    <= found_d;
            overrun_q  <= overrun_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_found   = found_q;
    assign o_row     = out_row_q;
    assign o_col     = out_col_q;
    assign o_overrun = overrun_q;
endmodule

// File: tb/tb_color_centroid_locator.sv
// Scoreboard bench: a reduced 64x48 raster for the main checks and a 5x2
// raster whose frames are short enough to land a frame end mid-division.
module tb_color_centroid_locator;
    localparam int H  = 64;
    localparam int V  = 48;
    localparam int HB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, sof = 1'b0;
    logic [31:0] data = 32'h0;
    logic        t_valid = 1'b0, t_sof = 1'b0;
    logic [31:0] t_data = 32'h0;

    logic       o_valid, o_found, o_overrun;
    logic [9:0] o_row, o_col;
    logic       s_valid, s_found, s_overrun;
    logic [9:0] s_row, s_col;

    always #5 clk = ~clk;

    color_centroid_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .HALF_BOX(HB), .MIN_PIXELS(20'd64)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_data(data),
        .o_valid(o_valid), .o_found(o_found), .o_row(o_row), .o_col(o_col), .o_overrun(o_overrun));

    color_centroid_locator #(.H_ACTIVE(5), .V_ACTIVE(2), .HALF_BOX(0), .MIN_PIXELS(20'd4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(t_valid), .i_sof(t_sof), .i_data(t_data),
        .o_valid(s_valid), .o_found(s_found), .o_row(s_row), .o_col(s_col), .o_overrun(s_overrun));

    typedef struct {
        bit found;
        int row;
        int col;
        int lat;
        int end_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Every cycle of the bench goes through here; results are popped the
    // moment the main DUT pulses o_valid.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, required no pending result", cyc);
            end else begin
                e = sb.pop_front();
                $display("result: found=%0d row=%0d col=%0d latency=%0d", o_found, o_row, o_col, cyc - e.end_cyc);
                n_checks += 3;
                if (o_found !== e.found) begin
                    n_fail++;
                    $display("FAIL found: got %0d, expected %0d", o_found, e.found);
                end
                if (o_row !== 10'(e.row)) begin
                    n_fail++;
                    $display("FAIL row: got %0d, expected %0d", o_row, e.row);
                end
                if (o_col !== 10'(e.col)) begin
                    n_fail++;
                    $display("FAIL col: got %0d, expected %0d", o_col, e.col);
                end
                if ((cyc - e.end_cyc) != e.lat) begin
                    n_fail++;
                    $display("FAIL latency: got %0d, expected %0d", cyc - e.end_cyc, e.lat);
                end
            end
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic [31:0] d);
        valid = v;
        sof   = s;
        data  = d;
        tick();
    endtask

    task automatic run_frame(input int r0, input int r1, input int c0, input int c1,
                             input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                             input bit push, input bit ef, input int er, input int ec);
        logic [31:0] d;
        exp_t        e;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                d = (r >= r0 && r <= r1 && c >= c0 && c <= c1) ? {8'h00, rr, gg, bb} : 32'h0;
                beat(1'b1, (r == 0 && c == 0), d);
            end
        end
        valid = 1'b0;
        sof   = 1'b0;
        data  = 32'h0;
        if (push) begin
            e.found   = ef;
            e.row     = er;
            e.col     = ec;
            e.lat     = ef ? 62 : 2;
            e.end_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks += 7;
        if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %0d, expected 0", o_valid); end
        if (o_found !== 1'b0)   begin n_fail++; $display("FAIL rst_found: got %0d, expected 0", o_found); end
        if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %0d, expected 0", o_overrun); end
        if (o_row !== 10'd24)   begin n_fail++; $display("FAIL rst_row: got %0d, expected 24", o_row); end
        if (o_col !== 10'd32)   begin n_fail++; $display("FAIL rst_col: got %0d, expected 32", o_col); end
        if (s_row !== 10'd1)    begin n_fail++; $display("FAIL rst_row_small: got %0d, expected 1", s_row); end
        if (s_col !== 10'd2)    begin n_fail++; $display("FAIL rst_col_small: got %0d, expected 2", s_col); end
        $display("reset: row=%0d col=%0d found=%0d overrun=%0d", o_row, o_col, o_found, o_overrun);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_black();
        run_frame(-1, -1, -1, -1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 24, 32);
        wait_idle();
    endtask

    task automatic test_block();
        run_frame(10, 29, 20, 39, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 19, 29);
        wait_idle();
    endtask

    task automatic test_clamp();
        run_frame(0, 9, 54, 63, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1, 8, 55);
        wait_idle();
    endtask

    task automatic test_threshold();
        run_frame(20, 27, 30, 37, 8'd160, 8'd96, 8'd96, 1'b1, 1'b1, 23, 33);
        wait_idle();
        run_frame(20, 27, 30, 37, 8'd159, 8'd96, 8'd96, 1'b1, 1'b0, 23, 33);
        wait_idle();
        run_frame(20, 27, 30, 37, 8'd160, 8'd97, 8'd96, 1'b1, 1'b0, 23, 33);
        wait_idle();
    endtask

    task automatic test_sof_realign();
        for (int i = 0; i < 1000; i++) beat(1'b1, (i == 0), 32'h00FF0000);
        run_frame(24, 39, 30, 45, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 31, 37);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        run_frame(5, 14, 5, 14, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 9, 9);
        run_frame(40, 47, 0, 11, 8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 39, 8);
        wait_idle();
        n_checks++;
        if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %0d, expected 0", o_overrun); end
    endtask

    task automatic test_reset_mid_div();
        run_frame(10, 29, 20, 39, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL middiv_valid: got %0d, expected 0", o_valid); end
        if (o_found !== 1'b0) begin n_fail++; $display("FAIL middiv_found: got %0d, expected 0", o_found); end
        if (o_row !== 10'd24) begin n_fail++; $display("FAIL middiv_row: got %0d, expected 24", o_row); end
        if (o_col !== 10'd32) begin n_fail++; $display("FAIL middiv_col: got %0d, expected 32", o_col); end
        $display("reset mid-division: row=%0d col=%0d found=%0d", o_row, o_col, o_found);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
    endtask

    task automatic test_overrun();
        int end0;
        int seen;
        int lat;
        end0 = 0;
        seen = 0;
        lat  = -1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 10; i++) begin
                t_valid = 1'b1;
                t_sof   = (i == 0);
                t_data  = 32'h00FF0000;
                tick();
                if (f == 0 && i == 9) end0 = cyc;
            end
        end
        t_valid = 1'b0;
        t_sof   = 1'b0;
        t_data  = 32'h0;
        n_checks++;
        if (s_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0d, expected 1", s_overrun); end
        for (int i = 0; i < 100 && seen == 0; i++) begin
            tick();
            if (s_valid === 1'b1) begin
                seen = 1;
                lat  = cyc - end0;
                $display("small result: found=%0d row=%0d col=%0d latency=%0d", s_found, s_row, s_col, lat);
                n_checks += 4;
                if (s_found !== 1'b1) begin n_fail++; $display("FAIL ovr_found: got %0d, expected 1", s_found); end
                if (s_row !== 10'd0)  begin n_fail++; $display("FAIL ovr_row: got %0d, expected 0", s_row); end
                if (s_col !== 10'd2)  begin n_fail++; $display("FAIL ovr_col: got %0d, expected 2", s_col); end
                if (lat != 62)        begin n_fail++; $display("FAIL ovr_latency: got %0d, expected 62", lat); end
            end
        end
        n_checks++;
        if (seen == 0) begin n_fail++; $display("FAIL ovr_timeout: no o_valid within 100 cycles, expected one"); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_valid === 1'b1) seen++;
        end
        n_checks += 2;
        if (seen != 0) begin n_fail++; $display("FAIL ovr_extra_valid: got %0d pulses, expected 0", seen); end
        if (s_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %0d, expected 1", s_overrun); end
    endtask

    initial begin
        test_reset();
        test_black();
        test_block();
        test_clamp();
        test_threshold();
        test_sof_realign();
        test_back_to_back();
        test_reset_mid_div();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
